// File: rtl/i2c_slave_target.sv
// i2c_slave_target: I2C target with a MEM_DEPTH x 8 memory and write strobes.
// Define I2C_SLAVE_AUTOINC_EN to auto-increment the memory pointer after each byte.
module i2c_slave_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h55,
  parameter int         MEM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       Wr_Strobe,
  output logic [7:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic       Busy
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_MEM_ADDR, S_ACK_MEM, S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_ACK
  } state_t;
  state_t        state;
  logic [7:0]    mem [MEM_DEPTH];
  logic [2:0]    scl_q, sda_q;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg, rx;
  logic [6:0]    tx;
  logic [AW-1:0] ptr, base, ptr_next;
  logic          rw, sda_oe, scl_rise, scl_fall, start, stop;
  assign SDA      = sda_oe ? 1'b0 : 1'bz;
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign rx       = {shreg[6:0], sda_q[1]};
`ifdef I2C_SLAVE_AUTOINC_EN
  assign ptr_next = ptr + 1'b1;
`else
  assign ptr_next = ptr;
`endif
  always_ff @(posedge clk)
    if (Wr_Strobe) mem[Wr_Addr[AW-1:0]] <= Wr_Data;
  // a START rewinds the pointer to the last received memory address
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      scl_q     <= '1;
      sda_q     <= '1;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      ptr       <= '0;
      base      <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      Wr_Strobe <= 1'b0;
      Wr_Addr   <= '0;
      Wr_Data   <= '0;
      Busy      <= 1'b0;
    end else begin
      scl_q     <= {scl_q[1:0], SCL};
      sda_q     <= {sda_q[1:0], SDA};
      Wr_Strobe <= 1'b0;
      if (stop) begin
        state   <= S_IDLE;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
        Busy    <= 1'b0;
      end else if (start) begin
        state   <= S_DEV_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
        ptr     <= base;
      end else begin
        case (state)
          S_DEV_ADDR, S_MEM_ADDR, S_WR_DATA: begin
            if (scl_rise) begin
              shreg   <= rx;
              bit_cnt <= bit_cnt + 1'b1;
              if (state == S_WR_DATA && bit_cnt == 4'd7) begin
                Wr_Strobe <= 1'b1;
                Wr_Addr   <= 8'(ptr);
                Wr_Data   <= rx;
                ptr       <= ptr_next;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == S_DEV_ADDR && shreg[7:1] != DEV_ADDR) begin
                state <= S_IDLE;
                Busy  <= 1'b0;
              end else begin
                sda_oe <= 1'b1;
                state  <= state == S_DEV_ADDR ? S_ACK_DEV : state == S_MEM_ADDR ? S_ACK_MEM : S_ACK_WR;
                if (state == S_DEV_ADDR) begin
                  Busy <= 1'b1;
                  rw   <= shreg[0];
                end
                if (state == S_MEM_ADDR) begin
                  ptr  <= shreg[AW-1:0];
                  base <= shreg[AW-1:0];
                end
              end
            end
          end
          S_ACK_DEV:
            if (scl_fall) begin
              bit_cnt <= '0;
              state   <= rw ? S_RD_DATA : S_MEM_ADDR;
              tx      <= mem[ptr][6:0];
              sda_oe  <= rw & ~mem[ptr][7];
            end
          S_ACK_MEM, S_ACK_WR:
            if (scl_fall) begin
              bit_cnt <= '0;
              state   <= S_WR_DATA;
              sda_oe  <= 1'b0;
            end
          S_RD_DATA:
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                state  <= S_RD_ACK;
                sda_oe <= 1'b0;
                ptr    <= ptr_next;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx      <= {tx[5:0], 1'b0};
                sda_oe  <= ~tx[6];
              end
            end
          S_RD_ACK:
            if (scl_rise && sda_q[1]) begin
              state <= S_IDLE;
              Busy  <= 1'b0;
            end else if (scl_fall) begin
              bit_cnt <= '0;
              state   <= S_RD_DATA;
              tx      <= mem[ptr][6:0];
              sda_oe  <= ~mem[ptr][7];
            end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_target.sv
// tb_i2c_slave_target: randomized I2C controller bench checked against a memory/pointer model.
module tb_i2c_slave_target;
  localparam logic [6:0] DEV = 7'h55;
  localparam int Q = 60;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  logic       clk = 1'b0, reset_n = 1'b0, scl = 1'b1, sda_o = 1'b1;
  wire        SDA;
  logic       Wr_Strobe, Busy;
  logic [7:0] Wr_Addr, Wr_Data;
  int         n_checks = 0, n_errors = 0;
  int         n_strobes = 0, sda_lows = 0, exp_n = 0, chk_idx = 0;
  logic [7:0] st_addr [256], st_data [256], exp_addr [256], exp_data [256];
  logic [7:0] mem_m [16];
  logic [3:0] ptr_m = '0, base_m = '0;
  logic [7:0] wbuf [4];

  pullup (SDA);
  assign SDA = sda_o ? 1'bz : 1'b0;
  always #5 clk = ~clk;

  i2c_slave_target dut (
    .clk(clk), .reset_n(reset_n), .SCL(scl), .SDA(SDA),
    .Wr_Strobe(Wr_Strobe), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Busy(Busy)
  );

  always @(negedge clk) begin
    if (Wr_Strobe && n_strobes < 256) begin
      st_addr[n_strobes] <= Wr_Addr;
      st_data[n_strobes] <= Wr_Data;
      n_strobes <= n_strobes + 1;
    end
    if (sda_o && SDA === 1'b0) sda_lows <= sda_lows + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] p);
    return AUTOINC ? 4'((int'(p) + 1) % 16) : p;
  endfunction

  task automatic i2c_start();
    sda_o = 1'b1; #Q; scl = 1'b1; #Q; sda_o = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_o = 1'b0; #Q; scl = 1'b1; #Q; sda_o = 1'b1; #Q;
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    sda_o = b; #Q; scl = 1'b1; #Q; r = (SDA !== 1'b0); #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    ack = !r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(nack, r);
  endtask

  task automatic cmp_strobes();
    check("strobe_cnt", n_strobes, exp_n);
    for (int i = chk_idx; i < exp_n && i < n_strobes; i++) begin
      check("strobe_addr", st_addr[i], exp_addr[i]);
      check("strobe_data", st_data[i], exp_data[i]);
    end
    chk_idx = exp_n;
  endtask

  task automatic wr_txn(input logic [7:0] a, input int n, input bit do_stop);
    logic ack;
    i2c_start();
    ptr_m = base_m;
    write_byte({DEV, 1'b0}, ack);
    check("dev_ack", ack, 1);
    check("busy_on", Busy, 1);
    write_byte(a, ack);
    check("addr_ack", ack, 1);
    base_m = 4'(a % 16);
    ptr_m  = base_m;
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      check("data_ack", ack, 1);
      mem_m[ptr_m]    = wbuf[i];
      exp_addr[exp_n] = {4'h0, ptr_m};
      exp_data[exp_n] = wbuf[i];
      exp_n++;
      ptr_m = nxt(ptr_m);
    end
    if (do_stop) begin
      i2c_stop();
      check("busy_off", Busy, 0);
    end
    cmp_strobes();
  endtask

  task automatic rd_txn(input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    ptr_m = base_m;
    write_byte({DEV, 1'b1}, ack);
    check("rd_dev_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check("rd_data", d, mem_m[ptr_m]);
      ptr_m = nxt(ptr_m);
    end
    i2c_stop();
    check("rd_busy_off", Busy, 0);
  endtask

  initial begin
    logic ack, r;
    logic [7:0] dw;
    int lows;
    repeat (4) @(negedge clk);
    check("rst_busy", Busy, 0);
    check("rst_strobe", Wr_Strobe, 0);
    check("rst_addr", Wr_Addr, 0);
    check("rst_data", Wr_Data, 0);
    check("rst_sda", SDA, 1);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    wbuf[0] = 8'hAA;
    wr_txn(8'h00, 1, 1'b1);
    lows = sda_lows;
    i2c_start();
    write_byte(8'h54, ack);
    check("other_nack", ack, 0);
    check("other_busy", Busy, 0);
    i2c_stop();
    check("other_sda_quiet", sda_lows - lows, 0);
    cmp_strobes();
    for (int a = 0; a < 16; a++) begin
      wbuf[0] = 8'($urandom);
      wr_txn(8'(a), 1, 1'b1);
    end
    wbuf[0] = 8'hAA;
    wbuf[1] = 8'h55;
    wr_txn(8'h00, 2, 1'b0);
    rd_txn(2);
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wr_txn(8'h0F, 2, 1'b1);
    rd_txn(2);
    repeat (12) begin
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      wr_txn(8'($urandom_range(0, 255)), n, 1'($urandom_range(0, 1)));
      rd_txn($urandom_range(1, 3));
    end
    i2c_start();
    write_byte({DEV, 1'b0}, ack);
    check("part_dev_ack", ack, 1);
    write_byte(8'h03, ack);
    check("part_addr_ack", ack, 1);
    base_m = 4'h3;
    for (int i = 0; i < 4; i++) i2c_bit(1'($urandom), r);
    i2c_stop();
    check("part_busy", Busy, 0);
    cmp_strobes();
    dw = {DEV, 1'b0};
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(dw[i], r);
    sda_o = 1'b1; #Q; scl = 1'b1; #(Q / 2);
    check("ack_before_rst", SDA, 0);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid_sda", SDA, 1);
    check("rst_mid_busy", Busy, 0);
    base_m = '0;
    #(Q / 2); scl = 1'b0; #Q;
    i2c_stop();
    cmp_strobes();
    rd_txn(1);
    wbuf[0] = 8'h5A;
    wr_txn(8'h07, 1, 1'b1);
    rd_txn(1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
